// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared opcodes, IR field positions and sequencer state encoding
package cpu_ctrl_pkg;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_SHR  = 5'b00100;
  localparam logic [4:0] OP_SHL  = 5'b00101;
  localparam logic [4:0] OP_ROR  = 5'b00110;
  localparam logic [4:0] OP_ROL  = 5'b00111;
  localparam logic [4:0] OP_ADDI = 5'b01000;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_T0     = 4'd1;
  localparam logic [3:0] ST_T1     = 4'd2;
  localparam logic [3:0] ST_T2     = 4'd3;
  localparam logic [3:0] ST_T3     = 4'd4;
  localparam logic [3:0] ST_T4     = 4'd5;
  localparam logic [3:0] ST_T5     = 4'd6;
  localparam logic [3:0] ST_T6     = 4'd7;
  localparam logic [3:0] ST_HALTED = 4'd8;

  typedef enum logic [2:0] {
    CLS_BINARY,
    CLS_ADDI,
    CLS_UNARY,
    CLS_MULDIV,
    CLS_NOP,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_e;

  // MUL/DIV fall into the illegal class when the multiply/divide unit is absent.
  function automatic op_class_e classify(input logic [4:0] op, input logic muldiv_en);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL: return CLS_BINARY;
      OP_ADDI:                        return CLS_ADDI;
      OP_NEG, OP_NOT:                 return CLS_UNARY;
      OP_MUL, OP_DIV:                 return muldiv_en ? CLS_MULDIV : CLS_ILLEGAL;
      OP_NOP:                         return CLS_NOP;
      OP_HALT:                        return CLS_HALT;
      default:                        return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/select_encode.sv
// rtl/select_encode.sv - 4-bit register index to 16-bit one-hot select with enable
module select_encode (
  input  logic [3:0]  index,
  input  logic        enable,
  output logic [15:0] onehot
);

  assign onehot = enable ? (16'h0001 << index) : 16'h0000;

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - Moore fetch/execute control sequencer; MULDIV_EN adds MUL/DIV sequencing
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        ZHighIn,
  output logic        ZLowIn,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        Cout,
  output logic        HIin,
  output logic        LOin,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic [4:0]  alu_op,
  output logic        busy,
  output logic        halted,
  output logic        illegal
);

`ifdef MULDIV_EN
  localparam logic MULDIV = 1'b1;
`else
  localparam logic MULDIV = 1'b0;
`endif

  logic [3:0] state;
  logic [3:0] state_next;
  logic       set_illegal;
  logic [4:0] op;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;
  op_class_e  cls;
  logic       unused_ir;

  assign op        = IR[OP_MSB:OP_LSB];
  assign ra        = IR[RA_MSB:RA_LSB];
  assign rb        = IR[RB_MSB:RB_LSB];
  assign rc        = IR[RC_MSB:RC_LSB];
  assign unused_ir = ^IR[RC_LSB-1:0];
  assign cls       = classify(op, MULDIV);

  always_comb begin
    state_next  = state;
    set_illegal = 1'b0;
    case (state)
      ST_IDLE:   if (run) state_next = ST_T0;
      ST_T0:     state_next = ST_T1;
      ST_T1:     if (mem_ready) state_next = ST_T2;
      ST_T2:     state_next = ST_T3;
      ST_T3: begin
        case (cls)
          CLS_NOP:     state_next = run ? ST_T0 : ST_IDLE;
          CLS_HALT:    state_next = ST_HALTED;
          CLS_ILLEGAL: begin
            state_next  = ST_HALTED;
            set_illegal = 1'b1;
          end
          default:     state_next = ST_T4;
        endcase
      end
      ST_T4:     state_next = ST_T5;
      ST_T5:     state_next = (cls == CLS_MULDIV) ? ST_T6 : (run ? ST_T0 : ST_IDLE);
      ST_T6:     state_next = run ? ST_T0 : ST_IDLE;
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state   <= ST_IDLE;
      illegal <= 1'b0;
    end else begin
      state <= state_next;
      if (set_illegal) illegal <= 1'b1;
    end
  end

  // Register bus selects: Rb is driven in T3 and for unary T4, Rc for two-operand T4.
  logic       rout_en;
  logic [3:0] rout_idx;
  logic       rin_en;

  assign rout_en  = (state == ST_T3) ||
                    ((state == ST_T4) && (cls == CLS_BINARY || cls == CLS_MULDIV || cls == CLS_UNARY));
  assign rout_idx = (state == ST_T4 && cls != CLS_UNARY) ? rc : rb;
  assign rin_en   = (state == ST_T5) && (cls != CLS_MULDIV) && (ra != 4'd0);

  select_encode u_rout_sel (
    .index  (rout_idx),
    .enable (rout_en),
    .onehot (Rout)
  );

  select_encode u_rin_sel (
    .index  (ra),
    .enable (rin_en),
    .onehot (Rin)
  );

  always_comb begin
    PCout    = (state == ST_T0);
    MARin    = (state == ST_T0);
    IncPC    = (state == ST_T0);
    Read     = (state == ST_T1);
    MDRin    = (state == ST_T1);
    MDRout   = (state == ST_T2);
    IRin     = (state == ST_T2);
    Yin      = (state == ST_T3);
    ZHighIn  = (state == ST_T4);
    ZLowIn   = (state == ST_T4);
    Cout     = (state == ST_T4) && (cls == CLS_ADDI);
    Zlowout  = (state == ST_T5);
    Zhighout = (state == ST_T6);
    alu_op   = (state == ST_T4) ? op : 5'b00000;
    busy     = (state != ST_IDLE) && (state != ST_HALTED);
    halted   = (state == ST_HALTED);
`ifdef MULDIV_EN
    HIin     = (state == ST_T6);
    LOin     = (state == ST_T5) && (cls == CLS_MULDIV);
`else
    HIin     = 1'b0;
    LOin     = 1'b0;
`endif
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - randomized bench for control_sequencer against a step-list reference model
module tb_control_sequencer;

  logic        clock;
  logic        clear;
  logic        run;
  logic        mem_ready;
  logic [31:0] IR;
  logic PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin, ZHighIn, ZLowIn;
  logic Zhighout, Zlowout, Cout, HIin, LOin;
  logic [15:0] Rin, Rout;
  logic [4:0]  alu_op;
  logic busy, halted, illegal;

  control_sequencer dut (
    .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .IR(IR),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Read(Read), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn),
    .Zhighout(Zhighout), .Zlowout(Zlowout), .Cout(Cout), .HIin(HIin), .LOin(LOin),
    .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .busy(busy), .halted(halted),
    .illegal(illegal)
  );

  typedef struct packed {
    logic PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin, ZHighIn, ZLowIn;
    logic Zhighout, Zlowout, Cout, HIin, LOin;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic [4:0]  alu_op;
    logic busy, halted, illegal;
  } ov_t;

  ov_t obs;
  assign obs = {PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin, ZHighIn, ZLowIn,
                Zhighout, Zlowout, Cout, HIin, LOin, Rin, Rout, alu_op, busy, halted, illegal};

  localparam int C_BIN = 0, C_ADDI = 1, C_UN = 2, C_MD = 3, C_NOP = 4, C_HALT = 5, C_ILL = 6;

`ifdef MULDIV_EN
  localparam bit HAS_MD = 1'b1;
`else
  localparam bit HAS_MD = 1'b0;
`endif

  int  tests = 0;
  int  fails = 0;
  bit  idle;
  ov_t exp_q[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int op_class(input logic [4:0] op);
    case (op)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7: return C_BIN;
      5'd8:         return C_ADDI;
      5'd17, 5'd18: return C_UN;
      5'd15, 5'd16: return HAS_MD ? C_MD : C_ILL;
      5'd26:        return C_NOP;
      5'd27:        return C_HALT;
      default:      return C_ILL;
    endcase
  endfunction

  function automatic ov_t busy_vec();
    ov_t e;
    e = '0;
    e.busy = 1'b1;
    return e;
  endfunction

  // Expected output per cycle of one instruction, from T0 through its final step.
  task automatic build(input logic [31:0] ir, input int w);
    ov_t e;
    int c;
    logic [3:0] ra, rb, rc;
    ra = ir[26:23];
    rb = ir[22:19];
    rc = ir[18:15];
    c  = op_class(ir[31:27]);
    exp_q.delete();
    e = busy_vec(); e.PCout = 1; e.MARin = 1; e.IncPC = 1; exp_q.push_back(e);
    for (int i = 0; i <= w; i++) begin
      e = busy_vec(); e.Read = 1; e.MDRin = 1; exp_q.push_back(e);
    end
    e = busy_vec(); e.MDRout = 1; e.IRin = 1; exp_q.push_back(e);
    e = busy_vec(); e.Yin = 1; e.Rout = 16'h1 << rb; exp_q.push_back(e);
    if (c == C_NOP || c == C_HALT || c == C_ILL) return;
    e = busy_vec(); e.alu_op = ir[31:27]; e.ZHighIn = 1; e.ZLowIn = 1;
    if (c == C_BIN || c == C_MD) e.Rout = 16'h1 << rc;
    else if (c == C_ADDI) e.Cout = 1;
    else e.Rout = 16'h1 << rb;
    exp_q.push_back(e);
    e = busy_vec(); e.Zlowout = 1;
    if (c == C_MD) e.LOin = 1;
    else if (ra != 0) e.Rin = 16'h1 << ra;
    exp_q.push_back(e);
    if (c == C_MD) begin
      e = busy_vec(); e.Zhighout = 1; e.HIin = 1; exp_q.push_back(e);
    end
  endtask

  task automatic do_instr(input string tag, input logic [31:0] ir, input int w,
                          input bit run_after, input int abort_at);
    int  n;
    int  c;
    ov_t hv;
    if (idle) run = 1'b1;
    build(ir, w);
    n = exp_q.size();
    c = op_class(ir[31:27]);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      check_eq($sformatf("%s.step%0d", tag, k), obs, exp_q[k]);
      if (k == 0) IR = ir;
      if (k == abort_at) begin
        clear = 1'b1; run = 1'($urandom); mem_ready = 1'($urandom);
        @(negedge clock);
        check_eq($sformatf("%s.abort", tag), obs, 64'd0);
        clear = 1'b0; run = 1'b0;
        idle = 1'b1;
        return;
      end
      if (k >= 1 && k <= w) mem_ready = 1'b0;
      else if (k == w + 1)  mem_ready = 1'b1;
      else                  mem_ready = 1'($urandom);
      run = (k == n - 1) ? run_after : 1'($urandom);
    end
    if (c == C_HALT || c == C_ILL) begin
      hv = '0; hv.halted = 1'b1; hv.illegal = (c == C_ILL);
      run = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clock);
        check_eq($sformatf("%s.halted%0d", tag, i), obs, hv);
        mem_ready = 1'($urandom);
      end
      clear = 1'b1;
      @(negedge clock);
      check_eq($sformatf("%s.cleared", tag), obs, 64'd0);
      clear = 1'b0; run = 1'b0;
      idle = 1'b1;
    end else if (!run_after) begin
      for (int i = 0; i < 2; i++) begin
        @(negedge clock);
        check_eq($sformatf("%s.park%0d", tag, i), obs, 64'd0);
        mem_ready = 1'($urandom);
      end
      idle = 1'b1;
    end else begin
      idle = 1'b0;
    end
  endtask

  logic [4:0] legal_ops [15] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
                                 5'd8, 5'd15, 5'd16, 5'd17, 5'd18, 5'd26, 5'd27};

  initial begin
    logic [4:0]  op;
    logic [31:0] ir;
    int          w;
    int          ab;
    clear = 1'b1; run = 1'b1; mem_ready = 1'b1; IR = 32'h0;
    @(negedge clock);
    check_eq("reset0", obs, 64'd0);
    @(negedge clock);
    check_eq("reset1", obs, 64'd0);
    clear = 1'b0; run = 1'b0;
    @(negedge clock);
    check_eq("idle_hold", obs, 64'd0);
    idle = 1'b1;

    do_instr("add_fast", 32'h0291_8000, 0, 1'b1, -1);
    do_instr("add_wait", 32'h0291_8000, 3, 1'b0, -1);
    do_instr("mul",      32'h7811_8000, 1, 1'b1, -1);
    do_instr("addi",     32'h4291_8000, 0, 1'b1, -1);
    do_instr("neg",      32'h8A90_0000, 2, 1'b1, -1);
    do_instr("nop",      32'hD000_0000, 0, 1'b0, -1);
    do_instr("add_abort_t4", 32'h0291_8000, 0, 1'b1, 4);
    do_instr("abort_t1_wait", 32'h0291_8000, 3, 1'b1, 2);
    do_instr("halt",     32'hD800_0000, 0, 1'b1, -1);
    do_instr("illegal",  32'hF800_0000, 1, 1'b1, -1);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) op = 5'($urandom);
      else op = legal_ops[$urandom_range(0, 14)];
      ir = {op, 27'($urandom)};
      w  = $urandom_range(0, 3);
      ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, w + 3) : -1;
      do_instr($sformatf("rnd%0d", i), ir, w, 1'($urandom), ab);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
